// File: rtl/axis_flow_monitor_64.sv
// axis_flow_monitor_64: per-flow frame/byte/error counters for a 64-bit AXI-Stream generator output.
// Latency: counters update on the tlast beat edge; the read port returns data one cycle after rd_en.
// Backpressure: none; every valid beat is accepted. Optional macro PAYLOAD_CHECK_EN compiles in the payload byte check.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   axis_tdata/tkeep/tvalid/tlast  monitored stream (byte 0 = tdata[7:0] = first on the wire)
//   clr                       pulse, zeroes all counters (FSM and frame state untouched)
//   rd_en, rd_addr            counter read: flow*4 + {0 frames, 1 bytes, 2 errors, 3 zero}, 4*N_FLOWS = unmatched
//   rd_data, rd_valid         registered read result, rd_valid pulses for one cycle per read
//   busy                      a frame is in progress
module axis_flow_monitor_64 #(
  parameter int                    N_FLOWS   = 4,
  parameter logic [48*N_FLOWS-1:0] D_MACS    = {48'hABCDEF000001, 48'hABCDEF000002,
                                                48'hABCDEF000003, 48'hABCDEF000004},
  parameter logic [8*N_FLOWS-1:0]  PAYLOADS  = {8'hAA, 8'hBB, 8'hCC, 8'hDD},
  parameter int                    CNT_WIDTH = 32,
  localparam int                   AW        = $clog2(4*N_FLOWS+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [63:0]          axis_tdata,
  input  logic [7:0]           axis_tkeep,
  input  logic                 axis_tvalid,
  input  logic                 axis_tlast,
  input  logic                 clr,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 busy
);

  localparam int FW    = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1;
  localparam int SUM_W = ((CNT_WIDTH > 16) ? CNT_WIDTH : 16) + 1;
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  typedef enum logic [1:0] {SOF = 2'd0, HDR = 2'd1, BODY = 2'd2} state_t;

  state_t state, state_nxt;

  // Per-frame state
  logic [FW-1:0] flow_id;
  logic          matched;
  logic [15:0]   len_acc;
  logic          ferr;

  // Counters
  logic [CNT_WIDTH-1:0] cnt_frm [N_FLOWS];
  logic [CNT_WIDTH-1:0] cnt_byt [N_FLOWS];
  logic [CNT_WIDTH-1:0] cnt_err [N_FLOWS];
  logic [CNT_WIDTH-1:0] cnt_unm;

  // Beat-level combinational results
  logic [47:0]   mac_in;
  logic          sof_hit;
  logic [FW-1:0] sof_id;
  logic          cur_hit;
  logic [FW-1:0] cur_id;
  logic [3:0]    beat_cnt;
  logic [15:0]   len_now;
  logic          keep_bad;
  logic          ferr_now;
  logic          err_now;
  logic          frame_done;

  function automatic logic [3:0] popcnt8(input logic [7:0] k);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, k[i]};
    return c;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] v,
                                                    input logic [15:0] a);
    logic [SUM_W-1:0] s;
    s = SUM_W'(v) + SUM_W'(a);
    return (s > SUM_W'(CMAX)) ? CMAX : s[CNT_WIDTH-1:0];
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= SOF;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (axis_tvalid) begin
      if (axis_tlast) begin
        state_nxt = SOF;
      end else begin
        case (state)
          SOF:     state_nxt = HDR;
          HDR:     state_nxt = BODY;
          default: state_nxt = BODY;
        endcase
      end
    end
  end

  always_comb begin
    busy = (state != SOF);
  end

  // ---------------- Classification ----------------
  // Destination MAC is the first six wire bytes, most significant first.
  always_comb begin
    mac_in  = {axis_tdata[7:0],   axis_tdata[15:8],  axis_tdata[23:16],
               axis_tdata[31:24], axis_tdata[39:32], axis_tdata[47:40]};
    sof_hit = 1'b0;
    sof_id  = '0;
    // Descending scan so the lowest matching index is the one left standing.
    for (int i = N_FLOWS - 1; i >= 0; i--) begin
      if (mac_in == D_MACS[48*i +: 48]) begin
        sof_hit = 1'b1;
        sof_id  = FW'(i);
      end
    end
  end

  // On the SOF beat the flow comes straight from the comparator so that
  // single-beat frames are classified too.
  assign cur_hit = (state == SOF) ? sof_hit : matched;
  assign cur_id  = (state == SOF) ? sof_id  : flow_id;

  // ---------------- Length and framing ----------------
  always_comb begin
    beat_cnt = popcnt8(axis_tkeep);
    len_now  = ((state == SOF) ? 16'd0 : len_acc) + 16'(beat_cnt);
    if (axis_tlast) begin
      // Last beat keep must be a non-empty run of ones from lane 0.
      keep_bad = (axis_tkeep == 8'h00) || ((axis_tkeep & (axis_tkeep + 8'd1)) != 8'h00);
    end else begin
      keep_bad = (axis_tkeep != 8'hFF);
    end
    ferr_now = ((state == SOF) ? 1'b0 : ferr) | keep_bad | (axis_tlast && (len_now < 16'd14));
  end

`ifdef PAYLOAD_CHECK_EN
  logic       perr;
  logic       perr_now;
  logic       pay_bad;
  logic [7:0] pay_exp;

  // Frame offset 14 onward: lanes 6..7 of the HDR beat and every lane of BODY beats.
  always_comb begin
    pay_exp = PAYLOADS[8*cur_id +: 8];
    pay_bad = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if (axis_tkeep[l] && ((state == BODY) || ((state == HDR) && (l >= 6))) &&
          (axis_tdata[8*l +: 8] != pay_exp)) begin
        pay_bad = 1'b1;
      end
    end
    perr_now = ((state == SOF) ? 1'b0 : perr) | pay_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perr <= 1'b0;
    end else if (axis_tvalid) begin
      perr <= axis_tlast ? 1'b0 : perr_now;
    end
  end

  assign err_now = ferr_now | perr_now;
`else
  logic unused_tdata_hi;
  assign unused_tdata_hi = ^axis_tdata[63:48];
  assign err_now = ferr_now;
`endif

  assign frame_done = axis_tvalid && axis_tlast;

  // Frame state is independent of clr: a frame in flight keeps counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      flow_id <= '0;
      matched <= 1'b0;
      len_acc <= '0;
      ferr    <= 1'b0;
    end else if (axis_tvalid) begin
      if (axis_tlast) begin
        len_acc <= '0;
        ferr    <= 1'b0;
      end else begin
        len_acc <= len_now;
        ferr    <= ferr_now;
        if (state == SOF) begin
          flow_id <= sof_id;
          matched <= sof_hit;
        end
      end
    end
  end

  // ---------------- Counters ----------------
  // clr beats a same-cycle frame update, so the completing frame is dropped.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < N_FLOWS; i++) begin
        cnt_frm[i] <= '0;
        cnt_byt[i] <= '0;
        cnt_err[i] <= '0;
      end
      cnt_unm <= '0;
    end else if (frame_done) begin
      if (cur_hit) begin
        for (int i = 0; i < N_FLOWS; i++) begin
          if (cur_id == FW'(i)) begin
            cnt_frm[i] <= sat_inc(cnt_frm[i]);
            cnt_byt[i] <= sat_add(cnt_byt[i], len_now);
            if (err_now) cnt_err[i] <= sat_inc(cnt_err[i]);
          end
        end
      end else begin
        cnt_unm <= sat_inc(cnt_unm);
      end
    end
  end

  // ---------------- Read port ----------------
  logic [CNT_WIDTH-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    if (int'(rd_addr) == 4*N_FLOWS) begin
      rd_mux = cnt_unm;
    end else begin
      for (int i = 0; i < N_FLOWS; i++) begin
        if (int'(rd_addr[AW-1:2]) == i) begin
          case (rd_addr[1:0])
            2'd0:    rd_mux = cnt_frm[i];
            2'd1:    rd_mux = cnt_byt[i];
            2'd2:    rd_mux = cnt_err[i];
            default: rd_mux = '0;
          endcase
        end
      end
    end
  end

  // Registered from the current counter values, so a read coinciding with
  // an update sees the value from before it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_axis_flow_monitor_64.sv
// Bench for axis_flow_monitor_64: directed frames, a frame-level reference model
// and literal expectations. A second instance with 4-bit counters shares the
// stimulus to exercise saturation.
module tb_axis_flow_monitor_64;

  localparam int NF = 4;
  localparam logic [48*NF-1:0] DM = {48'hABCDEF000001, 48'hABCDEF000002,
                                     48'hABCDEF000003, 48'hABCDEF000004};
  localparam logic [8*NF-1:0]  PL = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef PAYLOAD_CHECK_EN
  localparam bit PCE = 1'b1;
`else
  localparam bit PCE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] axis_tdata = '0;
  logic [7:0]  axis_tkeep = '0;
  logic        axis_tvalid = 1'b0;
  logic        axis_tlast = 1'b0;
  logic        clr = 1'b0;
  logic        rd_en = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic [3:0]  rd_data4;
  logic        rd_valid4;
  logic        busy4;

  always #5 clk = ~clk;

  axis_flow_monitor_64 dut (
    .clk(clk), .rst(rst), .axis_tdata(axis_tdata), .axis_tkeep(axis_tkeep),
    .axis_tvalid(axis_tvalid), .axis_tlast(axis_tlast), .clr(clr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
  );

  axis_flow_monitor_64 #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .axis_tdata(axis_tdata), .axis_tkeep(axis_tkeep),
    .axis_tvalid(axis_tvalid), .axis_tlast(axis_tlast), .clr(clr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data4), .rd_valid(rd_valid4), .busy(busy4)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- Reference model (frame level) ----------------
  longint      mf[NF], mb[NF], me[NF], mu;
  logic [63:0] bd[$];
  logic [7:0]  bk[$];
  bit          live = 1'b0;
  bit          pend = 1'b0;
  logic [63:0] ex32, ex4;

  function automatic void zero_model();
    for (int i = 0; i < NF; i++) begin mf[i] = 0; mb[i] = 0; me[i] = 0; end
    mu = 0;
  endfunction

  function automatic logic [63:0] lookup(input int a, input int w);
    longint v = 0;
    longint mx = (longint'(1) << w) - 1;
    if (a < 4*NF) begin
      case (a % 4)
        0: v = mf[a/4];
        1: v = mb[a/4];
        2: v = me[a/4];
        default: v = 0;
      endcase
    end else if (a == 4*NF) begin
      v = mu;
    end
    return (v > mx) ? mx : v;
  endfunction

  // Score a whole frame from its collected beats.
  function automatic void account();
    logic [191:0] dm = DM;
    logic [31:0]  pl = PL;
    logic [47:0]  mac;
    logic [7:0]   lk, pay;
    int nb = bd.size();
    int fid = -1;
    int len = 0;
    bit fe = 0, pe = 0;
    mac = {bd[0][7:0], bd[0][15:8], bd[0][23:16], bd[0][31:24], bd[0][39:32], bd[0][47:40]};
    for (int i = 0; i < NF; i++) if (fid < 0 && mac == dm[48*i +: 48]) fid = i;
    for (int j = 0; j < nb; j++) begin
      len += $countones(bk[j]);
      if (j < nb - 1 && bk[j] != 8'hFF) fe = 1;
    end
    lk = bk[nb-1];
    if (lk == 8'h00 || (lk & (lk + 8'd1)) != 8'h00) fe = 1;
    len = len % 65536;
    if (len < 14) fe = 1;
    if (fid >= 0) begin
      pay = pl[8*fid +: 8];
      for (int j = 0; j < nb; j++)
        for (int l = 0; l < 8; l++)
          if (bk[j][l] && (j*8 + l) >= 14 && bd[j][8*l +: 8] != pay) pe = 1;
    end
    if (!PCE) pe = 0;
    if (fid < 0) mu++;
    else begin
      mf[fid]++;
      mb[fid] += len;
      if (fe || pe) me[fid]++;
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      live = 1'b1;
      zero_model();
      bd.delete();
      bk.delete();
      pend = 1'b0;
    end else begin
      pend = rd_en;
      if (rd_en) begin
        ex32 = lookup(int'(rd_addr), 32);
        ex4  = lookup(int'(rd_addr), 4);
      end
      if (axis_tvalid) begin
        bd.push_back(axis_tdata);
        bk.push_back(axis_tkeep);
        if (axis_tlast) begin
          if (!clr) account();
          bd.delete();
          bk.delete();
        end
      end
      if (clr) zero_model();
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (live) begin
      chk("model rd_valid", rd_valid, pend);
      chk("model rd_valid4", rd_valid4, pend);
      if (pend) begin
        chk("model rd_data", rd_data, ex32);
        chk("model rd_data4", rd_data4, ex4);
      end
      chk("model busy", busy, bd.size() != 0);
      chk("model busy4", busy4, bd.size() != 0);
    end
  end

  // ---------------- Stimulus helpers ----------------
  logic [7:0] fb [0:255];
  int         flen;
  logic [3:0] last4;

  task automatic build(input logic [47:0] mac, input logic [7:0] pay, input int len);
    for (int i = 0; i < 6; i++) fb[i] = mac[47-8*i -: 8];
    fb[6] = 8'h02; fb[7] = 8'h00; fb[8] = 8'h00; fb[9] = 8'h00; fb[10] = 8'h00; fb[11] = 8'h01;
    fb[12] = 8'h88; fb[13] = 8'hB5;
    for (int i = 14; i < len; i++) fb[i] = pay;
    flen = len;
  endtask

  // Starts and ends just after a rising edge.
  task automatic send(input bit gaps, input int bad_beat, input bit clr_last, input int stop_after);
    int nb = (flen + 7) / 8;
    for (int j = 0; j < nb; j++) begin
      if (stop_after >= 0 && j == stop_after) begin
        axis_tvalid = 1'b0; axis_tlast = 1'b0;
        return;
      end
      if (gaps && (j % 3 == 1)) begin
        axis_tvalid = 1'b0; axis_tlast = 1'b1; axis_tkeep = 8'h01;
        @(posedge clk); #1;
      end
      for (int l = 0; l < 8; l++) begin
        if (8*j + l < flen) begin
          axis_tdata[8*l +: 8] = fb[8*j + l];
          axis_tkeep[l] = 1'b1;
        end else begin
          axis_tdata[8*l +: 8] = 8'h00;
          axis_tkeep[l] = 1'b0;
        end
      end
      if (j == bad_beat) axis_tkeep = 8'h7F;
      axis_tvalid = 1'b1;
      axis_tlast  = (j == nb - 1);
      clr         = clr_last && (j == nb - 1);
      @(posedge clk); #1;
    end
    axis_tvalid = 1'b0; axis_tlast = 1'b0; clr = 1'b0;
  endtask

  task automatic rd(input int a, input string nm, input logic [63:0] e);
    rd_en = 1'b1; rd_addr = 5'(a);
    @(negedge clk);
    chk({nm, " issue-cycle rd_valid"}, rd_valid, 0);
    @(posedge clk); #1;
    rd_en = 1'b0;
    @(negedge clk);
    chk({nm, " rd_valid"}, rd_valid, 1);
    chk(nm, rd_data, e);
    last4 = rd_data4;
    @(posedge clk); #1;
    chk({nm, " rd_valid pulse end"}, rd_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset busy", busy, 0);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset rd_data", rd_data, 0);

    // Flow 0, 192 bytes, clean
    build(48'hABCDEF000004, 8'hDD, 192);
    send(0, -1, 0, -1);
    rd(0,  "f0 frames", 1);
    rd(1,  "f0 bytes", 192);
    rd(2,  "f0 errors", 0);
    rd(4,  "f1 frames", 0);
    rd(16, "unmatched", 0);

    // Flow 3 with a corrupted payload byte
    build(48'hABCDEF000001, 8'hAA, 192);
    fb[100] = 8'h00;
    send(0, -1, 0, -1);
    rd(12, "f3 frames", 1);
    rd(13, "f3 bytes", 192);
    rd(14, "f3 errors", PCE ? 1 : 0);

    // Unmatched destination
    build(48'h112233445566, 8'hAA, 64);
    send(0, -1, 0, -1);
    rd(16, "unmatched after", 1);
    rd(8,  "f2 frames", 0);

    // 60-byte frame with gaps, partial last beat
    build(48'hABCDEF000003, 8'hCC, 60);
    send(1, -1, 0, -1);
    rd(5, "f1 bytes 60", 60);
    rd(6, "f1 errors clean", 0);
    // Same frame with a short middle beat
    send(1, 3, 0, -1);
    rd(6, "f1 errors midkeep", 1);
    rd(4, "f1 frames", 2);
    rd(5, "f1 bytes 119", 119);

    // Single-beat frame
    build(48'hABCDEF000002, 8'hBB, 8);
    send(0, -1, 0, -1);
    rd(8,  "f2 single frames", 1);
    rd(9,  "f2 single bytes", 8);
    rd(10, "f2 single errors", 1);
    rd(3,  "reserved", 0);
    rd(17, "out of range", 0);

    // Reset mid-frame
    build(48'hABCDEF000004, 8'hDD, 192);
    send(0, -1, 0, 2);
    chk("busy mid-frame", busy, 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("busy after reset", busy, 0);
    send(0, -1, 0, -1);
    rd(0, "f0 frames after reset", 1);
    rd(1, "f0 bytes after reset", 192);
    rd(2, "f0 errors after reset", 0);

    // Saturation: 16 minimum-size frames after a clear
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    build(48'hABCDEF000004, 8'hDD, 14);
    for (int n = 0; n < 16; n++) send(0, -1, 0, -1);
    rd(0, "f0 frames 16", 16);
    chk("sat frames 4b", last4, 15);
    rd(1, "f0 bytes 224", 224);
    chk("sat bytes 4b", last4, 15);
    rd(2, "f0 errors min len", 0);

    // Clear on the tlast beat, read the cycle after
    build(48'hABCDEF000001, 8'hAA, 60);
    send(0, -1, 1, -1);
    rd(12, "f3 frames after clr", 0);
    rd(0,  "f0 frames after clr", 0);
    rd(16, "unmatched after clr", 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
